// File: rtl/arbiter_rr4.sv
// Four-way round-robin arbiter that holds a grant until the owner is done or drops req.
// Define ARB_TIMEOUT_EN to add the hold counter and a forced release after MAX_HOLD cycles.
module arbiter_rr4 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic [1:0] win;
  logic       found;
  logic       hold_hit;
  logic       release_c;

  // Search for the first request at or above ptr, wrapping modulo 4.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[ptr + 2'(i)]) begin
        win   = ptr + 2'(i);
        found = 1'b1;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       timeout_q;

  assign hold_hit = (hold_cnt == 8'(MAX_HOLD));
  assign timeout  = timeout_q;

  // The count starts at 1 on entry, so it equals the number of GRANT cycles seen so far.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state == GRANT) && hold_hit && !done && req[owner];
      if (state == IDLE)
        hold_cnt <= found ? 8'd1 : 8'd0;
      else if (hold_cnt != 8'hFF)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = (MAX_HOLD != 0);
  assign hold_hit    = 1'b0;
  assign timeout     = 1'b0;
`endif

  assign release_c = done || !req[owner] || hold_hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      owner <= 2'd0;
    end else begin
      case (state)
        IDLE: if (found) begin
          state <= GRANT;
          owner <= win;
          ptr   <= win + 2'd1;
        end
        default: if (release_c) state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from state, so an asynchronous reset clears them immediately.
  assign busy   = (state == GRANT);
  assign gnt    = busy ? (4'b0001 << owner) : 4'b0000;
  assign gnt_id = busy ? owner : 2'd0;

endmodule

// File: tb/tb_arbiter_rr4.sv
// Directed, table-driven bench for arbiter_rr4 plus hand-written reset and hold-time sequences.
module tb_arbiter_rr4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  arbiter_rr4 #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [3:0] eg, input logic [1:0] ei,
                         input logic eb, input logic et);
    chk({name, ".gnt"}, gnt, eg);
    chk({name, ".gnt_id"}, {2'b00, gnt_id}, {2'b00, ei});
    chk({name, ".busy"}, {3'b000, busy}, {3'b000, eb});
    chk({name, ".timeout"}, {3'b000, timeout}, {3'b000, et});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Inputs are applied, one edge passes, and then the outputs are checked.
    vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[1]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[2]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[3]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[4]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[6]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[10] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[11] = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0};
    vecs[12] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[13] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[14] = '{4'b1011, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[15] = '{4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[16] = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[17] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0};

    do_reset();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].busy, vecs[i].tmo);
    end

    // ptr is now 2: requester 3 wins, then reset mid-cycle drops the grant without an edge.
    req  = 4'b1000;
    done = 1'b0;
    tick();
    chk_all("own3", 4'b1000, 2'd3, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 chk_all("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    #1 reset = 1'b1;
    req = 4'b1001;
    tick();
    chk_all("post_rst", 4'b0001, 2'd0, 1'b1, 1'b0);

`ifdef ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_all($sformatf("hold%0d", c + 1), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    tick();
    chk_all("forced", 4'b0000, 2'd0, 1'b0, 1'b1);
    tick();
    chk_all("after_tmo", 4'b0010, 2'd1, 1'b1, 1'b0);
    req = 4'b0001;
    tick();
    chk_all("rearb_idle", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk_all("rearb", 4'b0001, 2'd0, 1'b1, 1'b0);

    do_reset();
    req = 4'b0011;
    tick();
    tick();
    tick();
    tick();
    chk_all("hold4", 4'b0001, 2'd0, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_all("done_at_max", 4'b0000, 2'd0, 1'b0, 1'b0);
    done = 1'b0;
`else
    do_reset();
    req = 4'b0001;
    tick();
    for (int c = 0; c < 300; c++) begin
      chk($sformatf("long%0d.gnt", c), gnt, 4'b0001);
      chk($sformatf("long%0d.tmo", c), {3'b000, timeout}, 4'b0000);
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
